// File: rtl/accel_ctrl_gen2.sv
// Key-search accelerator controller: tracked buffer fill, level-by-level LC load, perf/key readback, stop latch.
// Latency: read data 2 cycles after command; LOAD starts the cycle after the buffer completes; one level per cycle.
// Backpressure: LC loads hold payload and level index while lc_ready is low; commands other than stop ignored while busy.
module accel_ctrl_gen2 #(
    parameter  int DATA_W          = 16,
    parameter  int BUF_DEPTH       = 16,
    parameter  int WORDS_PER_LEVEL = 4,
    parameter  int RD_AW           = 4,
    localparam int AW              = $clog2(BUF_DEPTH),
    localparam int LEVELS          = BUF_DEPTH / WORDS_PER_LEVEL,
    localparam int LVL_W           = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        control,
    input  logic                              wr_en,
    input  logic [AW-1:0]                     wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    input  logic [RD_AW-1:0]                  rd_addr,
    output logic [RD_AW-1:0]                  pckeyaddr,
    input  logic [DATA_W-1:0]                 pckeydata,
    output logic [DATA_W-1:0]                 dataToProc,
    output logic                              rd_valid,
    output logic [WORDS_PER_LEVEL*DATA_W-1:0] dataToLC,
    output logic                              startLC,
    input  logic                              lc_ready,
    output logic [LVL_W-1:0]                  levels,
    output logic                              busy,
    output logic                              load_done,
    output logic                              stop
);

    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;
    localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(LEVELS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_LOAD    = 3'd2,
        ST_READ    = 3'd3,
        ST_STOPPED = 3'd4
    } state_t;

    state_t                 r_state;
    logic [DATA_W-1:0]      r_buf [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]   r_bitmap;
    logic [LVL_W-1:0]       r_levels;
    logic                   r_load_done;
    logic                   r_stop;
    logic                   r_busy;
    logic                   r_startlc;
    logic [RD_AW-1:0]       r_pckeyaddr;
    logic [DATA_W-1:0]      r_data_to_proc;
    logic                   r_rd_valid;
    logic                   r_ret_stopped;   // READ returns to STOPPED when set, else IDLE

    logic                   w_wr_ok;
    logic [BUF_DEPTH-1:0]   w_wr_mask;
    logic [BUF_DEPTH-1:0]   w_bitmap_set;
    logic [WORDS_PER_LEVEL*DATA_W-1:0] w_data_to_lc;

    // Writes land only while the buffer is open (IDLE/FILL); mask carries this cycle's write into the bitmap.
    always_comb begin
        w_wr_ok      = wr_en && ((r_state == ST_IDLE) || (r_state == ST_FILL));
        w_wr_mask    = w_wr_ok ? (BUF_DEPTH'(1) << wr_addr) : '0;
        w_bitmap_set = r_bitmap | w_wr_mask;
    end

    // Current level payload, word 0 of the level in the most significant slot.
    always_comb begin
        w_data_to_lc = '0;
        for (int k = 0; k < WORDS_PER_LEVEL; k++) begin
            logic [AW-1:0] idx;
            idx = AW'(int'(r_levels) * WORDS_PER_LEVEL + k);
            w_data_to_lc[(WORDS_PER_LEVEL-1-k)*DATA_W +: DATA_W] = r_buf[idx];
        end
    end

    // Cipher buffer storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // Controller FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_bitmap       <= '0;
            r_levels       <= '0;
            r_load_done    <= 1'b0;
            r_stop         <= 1'b0;
            r_busy         <= 1'b0;
            r_startlc      <= 1'b0;
            r_pckeyaddr    <= '0;
            r_data_to_proc <= '0;
            r_rd_valid     <= 1'b0;
            r_ret_stopped  <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bitmap <= w_bitmap_set;
                    if (control == CMD_STOP) begin
                        r_state <= ST_STOPPED;
                        r_stop  <= 1'b1;
                    end else if (control == CMD_START) begin
                        // Clear tracking, but keep a write issued alongside the start.
                        r_state     <= ST_FILL;
                        r_bitmap    <= w_wr_mask;
                        r_levels    <= '0;
                        r_load_done <= 1'b0;
                        r_busy      <= 1'b1;
                    end else if (control == CMD_READ) begin
                        r_state       <= ST_READ;
                        r_pckeyaddr   <= rd_addr;
                        r_ret_stopped <= 1'b0;
                    end
                end
                ST_FILL: begin
                    r_bitmap <= w_bitmap_set;
                    if (control == CMD_STOP) begin
                        r_state <= ST_STOPPED;
                        r_stop  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (&w_bitmap_set) begin
                        r_state   <= ST_LOAD;
                        r_startlc <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (control == CMD_STOP) begin
                        r_state   <= ST_STOPPED;
                        r_stop    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_startlc <= 1'b0;
                    end else if (lc_ready) begin
                        if (r_levels == LAST_LVL) begin
                            r_state     <= ST_IDLE;
                            r_load_done <= 1'b1;
                            r_levels    <= '0;
                            r_startlc   <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_levels <= r_levels + 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (control == CMD_STOP) begin
                        // Aborted read: no data is returned.
                        r_state <= ST_STOPPED;
                        r_stop  <= 1'b1;
                    end else begin
                        r_data_to_proc <= pckeydata;
                        r_rd_valid     <= 1'b1;
                        r_state        <= r_ret_stopped ? ST_STOPPED : ST_IDLE;
                    end
                end
                ST_STOPPED: begin
                    if (control == CMD_START) begin
                        r_state     <= ST_FILL;
                        r_stop      <= 1'b0;
                        r_bitmap    <= '0;
                        r_levels    <= '0;
                        r_load_done <= 1'b0;
                        r_busy      <= 1'b1;
                    end else if (control == CMD_READ) begin
                        r_state       <= ST_READ;
                        r_pckeyaddr   <= rd_addr;
                        r_ret_stopped <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pckeyaddr  = r_pckeyaddr;
    assign dataToProc = r_data_to_proc;
    assign rd_valid   = r_rd_valid;
    assign dataToLC   = w_data_to_lc;
    assign startLC    = r_startlc;
    assign levels     = r_levels;
    assign busy       = r_busy;
    assign load_done  = r_load_done;
    assign stop       = r_stop;

endmodule

// File: tb/tb_accel_ctrl_gen2.sv
// Directed bench for accel_ctrl_gen2 with queue scoreboard for LC payloads and readback data.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// LC payload/readback expectations are pushed when stimulus is issued and popped on handshake/rd_valid.
module tb_accel_ctrl_gen2;

    localparam int DATA_W = 16;
    localparam int BUF_DEPTH = 16;
    localparam int WPL = 4;
    localparam int RD_AW = 4;
    localparam int AW = 4;
    localparam int LVL_W = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [1:0]              control;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic [RD_AW-1:0]        rd_addr;
    logic [RD_AW-1:0]        pckeyaddr;
    logic [DATA_W-1:0]       pckeydata;
    logic [DATA_W-1:0]       dataToProc;
    logic                    rd_valid;
    logic [WPL*DATA_W-1:0]   dataToLC;
    logic                    startLC;
    logic                    lc_ready;
    logic [LVL_W-1:0]        levels;
    logic                    busy;
    logic                    load_done;
    logic                    stop;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0]   mbuf [BUF_DEPTH];
    logic [WPL*DATA_W-1:0] lcq [$];
    logic [DATA_W-1:0]   rdq [$];

    accel_ctrl_gen2 #(
        .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .WORDS_PER_LEVEL(WPL), .RD_AW(RD_AW)
    ) dut (
        .clk(clk), .rst(rst), .control(control), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .pckeyaddr(pckeyaddr), .pckeydata(pckeydata),
        .dataToProc(dataToProc), .rd_valid(rd_valid), .dataToLC(dataToLC), .startLC(startLC),
        .lc_ready(lc_ready), .levels(levels), .busy(busy), .load_done(load_done), .stop(stop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WPL*DATA_W-1:0] mlevel(input int l);
        logic [WPL*DATA_W-1:0] v;
        v = '0;
        for (int k = 0; k < WPL; k++) v = {v[(WPL-1)*DATA_W-1:0], mbuf[l*WPL+k]};
        return v;
    endfunction

    task automatic push_levels();
        for (int l = 0; l < BUF_DEPTH / WPL; l++) lcq.push_back(mlevel(l));
    endtask

    // Score any handshake / readback happening in the current cycle, then advance one clock.
    task automatic step();
        if (startLC && lc_ready) begin
            if (lcq.size() == 0) chk("lc_unexpected_hs", {63'b0, startLC & lc_ready}, 64'd0);
            else chk("lc_payload", dataToLC, lcq.pop_front());
        end
        if (rd_valid) begin
            if (rdq.size() == 0) chk("rd_unexpected", {63'b0, rd_valid}, 64'd0);
            else chk("rd_data", dataToProc, {48'b0, rdq.pop_front()});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        mbuf[a] = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        logic [WPL*DATA_W-1:0] first_lvl;
        logic [LVL_W-1:0] exp_lv;
        logic [4:0] rdy_pat;

        rst = 1'b1; control = 2'b00; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; pckeydata = '0; lc_ready = 1'b0;
        @(posedge clk); #1;
        step();
        chk("rst_startLC", {63'b0, startLC}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_stop", {63'b0, stop}, 64'd0);
        chk("rst_load_done", {63'b0, load_done}, 64'd0);
        chk("rst_rd_valid", {63'b0, rd_valid}, 64'd0);
        chk("rst_levels", {62'b0, levels}, 64'd0);
        rst = 1'b0;
        step();

        // Full fill in descending order, then unstalled load.
        control = 2'b01; step(); control = 2'b00;
        chk("start_busy", {63'b0, busy}, 64'd1);
        for (int a = 15; a >= 1; a--) wr(a, 16'(16'h1000 + a));
        chk("fill15_startLC", {63'b0, startLC}, 64'd0);
        lc_ready = 1'b1;
        wr(0, 16'h1000);
        push_levels();
        chk("load_startLC", {63'b0, startLC}, 64'd1);
        first_lvl = dataToLC;
        chk("lvl0_const", first_lvl, 64'h1000_1001_1002_1003);
        for (int l = 0; l < 4; l++) begin
            chk("loadA_startLC", {63'b0, startLC}, 64'd1);
            chk("loadA_levels", {62'b0, levels}, 64'(l));
            step();
        end
        chk("loadA_done", {63'b0, load_done}, 64'd1);
        chk("loadA_startLC_off", {63'b0, startLC}, 64'd0);
        chk("loadA_busy_off", {63'b0, busy}, 64'd0);
        chk("loadA_levels0", {62'b0, levels}, 64'd0);
        lc_ready = 1'b0;

        // Overwrites of addr 3, addr 7 last; then stalled load.
        control = 2'b01; step(); control = 2'b00;
        chk("startB_load_done_clr", {63'b0, load_done}, 64'd0);
        wr(3, 16'hA001);
        for (int a = 0; a < 16; a++) if (a != 3 && a != 7) wr(a, 16'(16'h2000 + a));
        wr(3, 16'hA002);
        wr(3, 16'hA003);
        chk("fillB_busy", {63'b0, busy}, 64'd1);
        chk("fillB_no_load", {63'b0, startLC}, 64'd0);
        wr(7, 16'h2007);
        push_levels();
        chk("fillB_load", {63'b0, startLC}, 64'd1);
        chk("fillB_buf3", {48'b0, dataToLC[DATA_W-1:0]}, 64'hA003);
        rdy_pat = 5'b10010;  // applied LSB first: 0,1,0,0,1
        exp_lv = '0;
        for (int i = 0; i < 5; i++) begin
            lc_ready = rdy_pat[i];
            chk("stall_levels", {62'b0, levels}, 64'(exp_lv));
            chk("stall_payload", dataToLC, mlevel(int'(exp_lv)));
            step();
            if (rdy_pat[i]) exp_lv = exp_lv + 1'b1;
        end
        chk("stall_levels_end", {62'b0, levels}, 64'd2);

        // Stop during LOAD at level 2.
        lc_ready = 1'b0;
        control = 2'b11; step(); control = 2'b00;
        lcq.delete();
        chk("stop_stop", {63'b0, stop}, 64'd1);
        chk("stop_startLC", {63'b0, startLC}, 64'd0);
        chk("stop_busy", {63'b0, busy}, 64'd0);
        chk("stop_levels_frozen", {62'b0, levels}, 64'd2);
        step();
        rd_addr = 4'd5; pckeydata = 16'hBEEF;
        control = 2'b10; rdq.push_back(16'hBEEF); step(); control = 2'b00;
        rd_addr = 4'd0;
        chk("sread_addr", {60'b0, pckeyaddr}, 64'd5);
        chk("sread_no_valid_n1", {63'b0, rd_valid}, 64'd0);
        step();
        chk("sread_valid", {63'b0, rd_valid}, 64'd1);
        chk("sread_stop_held", {63'b0, stop}, 64'd1);
        step();
        chk("sread_pulse_end", {63'b0, rd_valid}, 64'd0);
        chk("sread_stop_after", {63'b0, stop}, 64'd1);
        control = 2'b01; step(); control = 2'b00;
        chk("restart_stop_clr", {63'b0, stop}, 64'd0);
        chk("restart_busy", {63'b0, busy}, 64'd1);

        // Fill again, stall in LOAD, then reset.
        for (int a = 0; a < 16; a++) wr(a, 16'(16'h3000 + a));
        chk("rl_startLC", {63'b0, startLC}, 64'd1);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rl_startLC0", {63'b0, startLC}, 64'd0);
        chk("rl_levels0", {62'b0, levels}, 64'd0);
        chk("rl_busy0", {63'b0, busy}, 64'd0);
        chk("rl_stop0", {63'b0, stop}, 64'd0);
        chk("rl_load_done0", {63'b0, load_done}, 64'd0);

        // IDLE read, start on the rd_valid cycle.
        pckeydata = 16'h1234; rd_addr = 4'hA;
        control = 2'b10; rdq.push_back(16'h1234); step(); control = 2'b00;
        rd_addr = 4'h0;
        chk("iread_addr", {60'b0, pckeyaddr}, 64'hA);
        chk("iread_no_valid_n1", {63'b0, rd_valid}, 64'd0);
        step();
        chk("iread_valid", {63'b0, rd_valid}, 64'd1);
        chk("iread_data", {48'b0, dataToProc}, 64'h1234);
        control = 2'b01; step(); control = 2'b00;
        chk("iread_pulse_end", {63'b0, rd_valid}, 64'd0);
        chk("iread_start_busy", {63'b0, busy}, 64'd1);
        chk("iread_data_held", {48'b0, dataToProc}, 64'h1234);

        chk("lcq_drained", 64'(lcq.size()), 64'd0);
        chk("rdq_drained", 64'(rdq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accel_ctrl_gen2.md
# accel_ctrl_gen2

Parametrised second-generation controller for the key-search accelerator. It sits between the processor command/data port and the level-chain (LC) cores. It fills a cipher-text buffer with tracked, out-of-order writes. It loads the buffer into the LC one level at a time using a valid/ready handshake, serves readback of performance-count/key words, and latches the found/stop condition while still allowing key readback.

## Interface
- DATA_W, 16, processor word width
- BUF_DEPTH, 16, cipher buffer depth in words; power of 2; divisible by WORDS_PER_LEVEL
- WORDS_PER_LEVEL, 4, words concatenated per LC load
- RD_AW, 4, readback address width
- Derived: AW = clog2(BUF_DEPTH); LEVELS = BUF_DEPTH/WORDS_PER_LEVEL; LVL_W = max(1, clog2(LEVELS))

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- control  in  2  00 nop, 01 start, 10 read, 11 stop; sampled every cycle
- wr_en  in  1  buffer write strobe
- wr_addr  in  AW  buffer write index
- wr_data  in  DATA_W  buffer write data
- rd_addr  in  RD_AW  readback address, sampled with read command
- pckeyaddr  out  RD_AW  registered address to perf-count/key source
- pckeydata  in  DATA_W  combinational read data for pckeyaddr
- dataToProc  out  DATA_W  registered readback data
- rd_valid  out  1  one-cycle pulse, dataToProc valid
- dataToLC  out  WORDS_PER_LEVEL*DATA_W  current level payload
- startLC  out  1  LC valid
- lc_ready  in  1  LC ready
- levels  out  LVL_W  current level index
- busy  out  1  high in FILL or LOAD
- load_done  out  1  sticky, all levels accepted
- stop  out  1  found/stop latched

## Operation
- States: IDLE, FILL, LOAD, READ, STOPPED. Registered outputs reset to 0 and state resets to IDLE; buffer contents are not reset.
- Valid bitmap (BUF_DEPTH bits) marks entries written since the last start.
- Writes (wr_en) store wr_data at wr_addr and set its bitmap bit in IDLE and FILL only. They are ignored in LOAD, READ and STOPPED. Overwrites are allowed; the last write wins and counts once.
- IDLE:
  - start → FILL; clears bitmap, levels, load_done.
  - read → READ.
  - stop → STOPPED.
  - A write in the same cycle as start is kept and sets its bit after the clear.
- FILL: when the bitmap is all-ones (including the write of this cycle), go to LOAD next cycle. Commands other than stop are ignored.
- LOAD:
  - startLC = 1.
  - dataToLC = {buf[levels*W], …, buf[levels*W+W-1]}, with word 0 in the MSBs (W = WORDS_PER_LEVEL).
  - On startLC & lc_ready, levels increments.
  - On the handshake at levels = LEVELS-1: go to IDLE, set load_done, and return levels to 0.
  - dataToLC and levels stay stable while stalled.
  - Commands other than stop are ignored.
- READ:
  - pckeyaddr holds the rd_addr captured with the command.
  - dataToProc <= pckeydata.
  - Return to the originating state (IDLE or STOPPED), held in a return bit.
- Stop command in any state → STOPPED.
  - Aborts FILL/LOAD; startLC is 0 from the next cycle.
  - levels and bitmap are frozen.
- STOPPED:
  - stop = 1.
  - read → READ, and stop stays 1 throughout.
  - start → FILL; clears stop, bitmap, levels, load_done.
  - nop/stop stays.
- busy = (FILL | LOAD). startLC = LOAD.

## Timing
- Read: command at cycle N. pckeyaddr valid from N+1. dataToProc updates and rd_valid = 1 at N+2 only. The next read is accepted at N+2.
- Fill complete at cycle N (last bit set by the write at N) → LOAD and startLC = 1 at N+1.
- LC handshake: one level per cycle at full throughput. The last level's handshake at N gives IDLE, load_done = 1, startLC = 0 at N+1.
- Start → FILL and busy = 1 at N+1. Stop → stop = 1 and busy = 0 at N+1.
- rst asserted at any edge, mid-fill/load/read, returns all outputs to 0 next cycle. No rd_valid is issued for an aborted read.

## Test plan
- Reset mid-LOAD with lc_ready = 0 → next cycle startLC = 0, levels = 0, busy = 0, stop = 0, load_done = 0.
- Start, then write addresses 15..0 descending with data 0x1000+addr, lc_ready = 1 → startLC for 4 consecutive cycles; dataToLC = 0x1000_1001_1002_1003, then …_1004…, through 0x100C_100D_100E_100F; load_done = 1.
- Start, write addr 3 three times plus 14 others (addr 7 missing) → stays in FILL, busy = 1. The write to 7 gives LOAD next cycle with buf[3] = last value written.
- In LOAD, toggle lc_ready 0,1,0,0,1 → levels advances only on ready cycles and dataToLC is stable while stalled.
- Stop during LOAD at level 2 → stop = 1 and startLC = 0 next cycle. Then read rd_addr = 5 with pckeydata = 0xBEEF → rd_valid pulse, dataToProc = 0xBEEF, stop still 1. Then start → stop = 0, FILL.
- IDLE read rd_addr = 0xA with pckeydata = 0x1234 → pckeyaddr = 0xA at N+1; dataToProc = 0x1234 and rd_valid = 1 at N+2 only. A start on the same cycle as rd_valid enters FILL.
